// File: rtl/cnn_acc_requant.sv
// Accumulates N_TERMS signed products plus a bias, then rounds and saturates to OUT_W bits.
// Optional ReLU on the requantized result: define CNN_ACC_REQUANT_RELU_EN.
module cnn_acc_requant #(
   parameter int PROD_W     = 24,
   parameter int ACC_W      = 32,
   parameter int OUT_W      = 14,
   parameter int N_TERMS    = 25,
   parameter int FRAC_SHIFT = 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [PROD_W-1:0] s_prod_data,
   input  logic              s_prod_valid,
   output logic              s_prod_ready,
   input  logic [OUT_W-1:0]  bias,
   output logic [OUT_W-1:0]  m_out_data,
   output logic              m_out_valid,
   input  logic              m_out_ready,
   output logic              m_out_sat,
   output logic              busy
);

   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   // Rounding width also covers the shifted bias when FRAC_SHIFT is large.
   localparam int T_W   = ((ACC_W > OUT_W + FRAC_SHIFT) ? ACC_W : OUT_W + FRAC_SHIFT) + 2;

   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(N_TERMS - 1);
   localparam logic signed [T_W-1:0] OUT_MAX    = (T_W'(1) <<< (OUT_W - 1)) - T_W'(1);
   localparam logic signed [T_W-1:0] OUT_MIN    = -OUT_MAX - T_W'(1);
   localparam logic signed [T_W-1:0] ROUND_HALF = T_W'(1) <<< (FRAC_SHIFT - 1);

   typedef enum logic [1:0] {
      ACC,
      ROUND,
      OUT
   } state_t;

   state_t                    state, state_nxt;
   logic signed [ACC_W-1:0]   acc, acc_nxt;
   logic        [CNT_W-1:0]   cnt, cnt_nxt;
   logic signed [OUT_W-1:0]   bias_q, bias_nxt;
   logic        [OUT_W-1:0]   data_nxt;
   logic                      sat_nxt;
   logic                      valid_nxt;
   logic                      accept;
   logic                      handshake;
   logic signed [T_W-1:0]     t;
   logic signed [T_W-1:0]     r;
   logic        [OUT_W-1:0]   q_data;
   logic                      q_sat;

   assign s_prod_ready = (state == ACC);
   assign accept       = s_prod_valid & s_prod_ready;
   assign handshake    = m_out_valid & m_out_ready;
   assign busy         = (state != ACC) || (cnt != '0);

   // Round half toward +inf, then clamp to the activation range.
   always_comb begin
      t      = T_W'(acc) + (T_W'(bias_q) <<< FRAC_SHIFT) + ROUND_HALF;
      r      = t >>> FRAC_SHIFT;
      q_data = r[OUT_W-1:0];
      q_sat  = 1'b0;
      if (r > OUT_MAX) begin
         q_data = OUT_MAX[OUT_W-1:0];
         q_sat  = 1'b1;
      end else if (r < OUT_MIN) begin
`ifdef CNN_ACC_REQUANT_RELU_EN
         q_data = '0;
`else
         q_data = OUT_MIN[OUT_W-1:0];
         q_sat  = 1'b1;
`endif
      end
`ifdef CNN_ACC_REQUANT_RELU_EN
      else if (r[T_W-1]) begin
         q_data = '0;
      end
`endif
   end

   // NOTE: every variable gets a default first, so no branch can infer a latch.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      bias_nxt  = bias_q;
      data_nxt  = m_out_data;
      sat_nxt   = m_out_sat;
      valid_nxt = m_out_valid;
      unique case (state)
         ACC: begin
            if (accept) begin
               acc_nxt = ((cnt == '0) ? '0 : acc) + ACC_W'($signed(s_prod_data));
               if (cnt == '0)
                  bias_nxt = $signed(bias);
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = ROUND;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         ROUND: begin
            data_nxt  = q_data;
            sat_nxt   = q_sat;
            valid_nxt = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            if (handshake) begin
               valid_nxt = 1'b0;
               state_nxt = ACC;
            end
         end
         default: state_nxt = ACC;
      endcase
   end

   // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
   always_ff @(posedge ap_clk) begin
      if (ap_rst)
         state <= ACC;
      else
         state <= state_nxt;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         acc         <= '0;
         cnt         <= '0;
         bias_q      <= '0;
         m_out_data  <= '0;
         m_out_sat   <= 1'b0;
         m_out_valid <= 1'b0;
      end else begin
         acc         <= acc_nxt;
         cnt         <= cnt_nxt;
         bias_q      <= bias_nxt;
         m_out_data  <= data_nxt;
         m_out_sat   <= sat_nxt;
         m_out_valid <= valid_nxt;
      end
   end

endmodule
